// File: rtl/cache_mem_pkg.sv
// cache_mem_pkg: shared widths and adaptor state encoding for the cache memory path
package cache_mem_pkg;
    localparam int LINE_WIDTH  = 256;
    localparam int BEAT_WIDTH  = 64;
    localparam int BEATS       = LINE_WIDTH / BEAT_WIDTH;
    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam int CNT_WIDTH   = $clog2(BEATS);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} adaptor_state_t;
endpackage

// File: rtl/cacheline_burst_adaptor.sv
// cacheline_burst_adaptor: turns one cacheline read/write into a multi-beat memory burst
module cacheline_burst_adaptor
    import cache_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           line_address,
    input  logic [LINE_WIDTH-1:0] line_wdata,
    input  logic                  line_read,
    input  logic                  line_write,
    output logic                  line_resp,
    output logic [LINE_WIDTH-1:0] line_rdata,
    output logic [31:0]           burst_address,
    output logic [BEAT_WIDTH-1:0] burst_wdata,
    output logic                  burst_read,
    output logic                  burst_write,
    input  logic                  burst_resp,
    input  logic [BEAT_WIDTH-1:0] burst_rdata
);
    adaptor_state_t        state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [LINE_WIDTH-1:0] line_buf, line_next;
    logic                  last, unused_offset;

    assign last          = cnt == CNT_WIDTH'(BEATS - 1);
    assign unused_offset = ^line_address[OFFSET_BITS-1:0];
    assign burst_wdata   = burst_write ? line_buf[BEAT_WIDTH*int'(cnt) +: BEAT_WIDTH] : '0;

    // One buffer serves as write source or read assembly, never both at once
    always_comb begin
        line_next = line_buf;
        line_next[BEAT_WIDTH*int'(cnt) +: BEAT_WIDTH] = burst_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            line_buf      <= '0;
            line_rdata    <= '0;
            line_resp     <= 1'b0;
            burst_address <= '0;
            burst_read    <= 1'b0;
            burst_write   <= 1'b0;
        end else begin
            line_resp <= 1'b0;
            case (state)
                IDLE: begin
                    burst_address <= {line_address[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    cnt           <= '0;
                    if (line_read) begin
                        state      <= READ;
                        burst_read <= 1'b1;
                    end else if (line_write) begin
                        state       <= WRITE;
                        burst_write <= 1'b1;
                        line_buf    <= line_wdata;
                    end
                end
                READ, WRITE: if (burst_resp) begin
                    cnt <= cnt + CNT_WIDTH'(1);
                    if (state == READ) line_buf <= line_next;
                    if (last) begin
                        state       <= DONE;
                        burst_read  <= 1'b0;
                        burst_write <= 1'b0;
                        line_resp   <= 1'b1;
                        if (state == READ) line_rdata <= line_next;
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// tb_cacheline_burst_adaptor: table-driven bench with a line-response scoreboard
module tb_cacheline_burst_adaptor;
    import cache_mem_pkg::*;

    logic                  clk = 1'b0, rst = 1'b1;
    logic [31:0]           line_address = '0;
    logic [LINE_WIDTH-1:0] line_wdata = '0, line_rdata;
    logic                  line_read = 1'b0, line_write = 1'b0, line_resp;
    logic [31:0]           burst_address;
    logic [BEAT_WIDTH-1:0] burst_wdata, burst_rdata = '0;
    logic                  burst_read, burst_write, burst_resp = 1'b0;

    cacheline_burst_adaptor dut (
        .clk(clk), .rst(rst), .line_address(line_address), .line_wdata(line_wdata),
        .line_read(line_read), .line_write(line_write), .line_resp(line_resp),
        .line_rdata(line_rdata), .burst_address(burst_address), .burst_wdata(burst_wdata),
        .burst_read(burst_read), .burst_write(burst_write), .burst_resp(burst_resp),
        .burst_rdata(burst_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              wr;
        bit              both;
        logic [31:0]     addr;
        logic [255:0]    data;
        int              gap_at;
        int              gap_len;
    } vec_t;

    typedef struct {
        logic [255:0] rdata;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    vec_t         vecs[6];
    int           checks = 0, errors = 0;
    logic [255:0] model_rdata = '0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge while the DUT is in IDLE; returns at the negedge of the IDLE cycle after DONE
    task automatic do_txn(input vec_t v);
        int          b = 0, g = 0, k = 0;
        bit          seen = 0;
        exp_t        e, got;
        logic [31:0] al;
        al      = {v.addr[31:5], 5'b0};
        e.rdata = v.wr ? model_rdata : v.data;
        e.lat   = 5 + v.gap_len;
        if (!v.wr) model_rdata = v.data;
        sb.push_back(e);
        line_address = v.addr;
        line_wdata   = v.wr ? v.data : {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        line_read    = !v.wr;
        line_write   = v.wr || v.both;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            line_address = $urandom;
            line_wdata   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            chk("burst_read", burst_read, !v.wr && b < BEATS);
            chk("burst_write", burst_write, v.wr && b < BEATS);
            if (b < BEATS) chk("burst_address", burst_address, al);
            if (line_resp) begin
                seen = 1;
                got  = sb.pop_front();
                chk("latency", k, got.lat);
                chk("line_rdata", line_rdata, got.rdata);
                burst_resp = 1'b0;
                line_read  = 1'b0;
                if (!v.both) line_write = 1'b0;
            end else if (b < BEATS && !(b == v.gap_at && g < v.gap_len)) begin
                burst_resp  = 1'b1;
                burst_rdata = v.data[64*b +: 64];
                if (v.wr) chk("burst_wdata", burst_wdata, v.data[64*b +: 64]);
                b++;
            end else begin
                burst_resp  = 1'b0;
                burst_rdata = {$urandom, $urandom};
                if (b == v.gap_at) g++;
            end
        end
        burst_resp = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout: no line_resp after %0d cycles, required within %0d", k, e.lat);
            sb.delete();
            line_read  = 1'b0;
            line_write = 1'b0;
        end
        @(negedge clk);
        chk("single_pulse", line_resp, 1'b0);
        chk("idle_read", burst_read, 1'b0);
        chk("idle_write", burst_write, 1'b0);
    endtask

    initial begin
        vec_t w;
        vecs[0] = '{0, 0, 32'h0000_1234, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 0};
        vecs[1] = '{0, 0, 32'h0000_1234, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 2, 2};
        vecs[2] = '{1, 0, 32'h8000_0040, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                    64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 0, 0};
        vecs[3] = '{0, 0, 32'hFFFF_FFFF, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                    64'hDEAD_BEEF_CAFE_F00D, 64'h0F0F_0F0F_F0F0_F0F0}, 3, 1};
        vecs[4] = '{1, 0, 32'h0000_001F, {64'h5555_0000_5555_0000, 64'h6666_1111_6666_1111,
                    64'h7777_2222_7777_2222, 64'h8888_3333_8888_3333}, 1, 3};
        vecs[5] = '{0, 0, 32'h1357_9BDF, {64'hA5A5_A5A5_5A5A_5A5A, 64'h0000_0000_0000_0001,
                    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF}, 0, 0};

        line_address = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        chk("rst_line_resp", line_resp, 1'b0);
        chk("rst_burst_read", burst_read, 1'b0);
        chk("rst_burst_write", burst_write, 1'b0);
        chk("rst_burst_address", burst_address, 32'h0);
        chk("rst_burst_wdata", burst_wdata, 64'h0);
        chk("rst_line_rdata", line_rdata, 256'h0);
        rst = 1'b0;
        line_address = '0;
        @(negedge clk);

        // Back-to-back table: each transaction starts the cycle after the previous one returns to IDLE
        for (int i = 0; i < 6; i++) do_txn(vecs[i]);

        // Read and write both requested: read first, then the still-held write
        w      = vecs[2];
        w.addr = 32'h4000_0080;
        w.data = {64'h0808_0808_0808_0808, 64'h0707_0707_0707_0707, 64'h0606_0606_0606_0606, 64'h0505_0505_0505_0505};
        vecs[0].both = 1'b1;
        do_txn(vecs[0]);
        do_txn(w);

        // Both requested, write dropped after the read completes: nothing follows
        vecs[3].both = 1'b1;
        do_txn(vecs[3]);
        line_write = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("dropped_write", burst_write, 1'b0);
            chk("dropped_read", burst_read, 1'b0);
        end

        // Reset after beat 1 of a read abandons the line
        line_address = 32'h0000_2000;
        line_read    = 1'b1;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            chk("pre_rst_burst_read", burst_read, 1'b1);
            burst_resp  = 1'b1;
            burst_rdata = {2{$urandom}};
        end
        @(negedge clk);
        burst_resp = 1'b0;
        line_read  = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_rdata = '0;
        chk("mid_rst_burst_read", burst_read, 1'b0);
        chk("mid_rst_line_resp", line_resp, 1'b0);
        chk("mid_rst_line_rdata", line_rdata, 256'h0);
        @(negedge clk);
        chk("mid_rst_no_resp", line_resp, 1'b0);
        do_txn(vecs[5]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
